memfifo_rd_checker: RTL and testbench
=====================================

# memfifo_rd_checker

Downstream consumer of the `memfifo_re` pulse train produced during Data_Request simulation. Converts each `memfifo_re` cycle into a gated read of the memory FIFO and captures the returned word after the FIFO's fixed read latency. Checks every word against an incrementing pattern and reports word count, error count, underflow and completion for the session. It sits between the read-enable generator and the memory FIFO read port.

## Interface
Parameters:
- `DATA_WIDTH`, 64: FIFO read data width.
- `RD_LATENCY`, 1: cycles from `fifo_re` to valid `fifo_rdata`; legal range 1–4.
- `PKT_WORDS`, 2: FIFO words per packet.
- `SEED`, 0: pattern value expected for the first word of a session.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle session start; sampled only in IDLE.
- `packet_no`  in  16  packets in the session; sampled with `start`.
- `memfifo_re`  in  1  read request; one word per high cycle.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data.
- `fifo_re`  out  1  gated FIFO read enable.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `word_cnt`  out  17  words checked this session.
- `err_cnt`  out  16  mismatches, saturating at 0xFFFF.
- `underflow`  out  1  sticky: `memfifo_re` seen while `fifo_empty`.
- `spurious`  out  1  sticky: `memfifo_re` seen outside RUN.
- `first_err_idx`  out  17  `word_cnt` value at the first mismatch.

## Operation
- State machine: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE, `start`=1:
  - `target` = `packet_no` × `PKT_WORDS`, 17-bit, no truncation.
  - Clear `issued`, `word_cnt`, `err_cnt`, `underflow`, `spurious`, `first_err_idx`.
  - Set `expect` = `SEED`; go to RUN.
- IDLE, `start`=1 and `target`=0: go directly to DRAIN.
- RUN: `fifo_re` = `memfifo_re` & ~`fifo_empty` & (`issued` < `target`). `fifo_re` is combinational, same cycle.
- Each `fifo_re` increments `issued`.
- `memfifo_re` & `fifo_empty` in RUN: set `underflow`, no read, `issued` unchanged.
- RUN → DRAIN in the cycle after `issued` reaches `target`.
- `memfifo_re` in IDLE, DRAIN or DONE: set `spurious`, `fifo_re` stays 0.
- Valid pipeline: `fifo_re` delayed by `RD_LATENCY` marks the cycle in which `fifo_rdata` is compared.
- Compare `fifo_rdata` against `expect` zero-extended to `DATA_WIDTH`.
  - On every compare: `word_cnt`++ and `expect`++ (wraps at 2^DATA_WIDTH).
  - On mismatch: `err_cnt`++ with saturation. On the first mismatch, latch `first_err_idx` = pre-increment `word_cnt`.
- DRAIN → DONE when the valid pipeline is empty.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy` or in DONE: ignored, no state change.
- `rst` mid-session: immediate return to IDLE. The in-flight pipeline is discarded and never compared.
- Status outputs hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: all outputs 0, state IDLE, `expect`=`SEED`.
- `fifo_re` has zero latency from `memfifo_re`.
- Data for a `fifo_re` in cycle T is compared at the edge ending cycle T+`RD_LATENCY`. `word_cnt` reflects it in cycle T+`RD_LATENCY`+1.
- Last `fifo_re` in cycle T → `done` high in cycle T+`RD_LATENCY`+2, `busy` low the same cycle.
- `target`=0: `start` in cycle S → `done` in cycle S+2.
- Back-to-back `memfifo_re` (every cycle) is supported at one word per cycle.

## Structure
- Package `memfifo_chk_pkg`: state enum (IDLE, RUN, DRAIN, DONE), the 17-bit count width constant, and the pattern-expansion function (zero-extension of `expect`).
- Sub-module `rd_valid_pipe`: `RD_LATENCY`-deep shift register of `fifo_re` with synchronous clear on `rst`. It exposes `vld_out` and `pipe_empty`.

## Test plan
- `packet_no`=3, `SEED`=0, FIFO preloaded with 0..5, `memfifo_re` every 9 cycles → 6 `fifo_re` pulses; `word_cnt`=6, `err_cnt`=0, one `done` pulse at last `fifo_re`+3.
- Same setup with word 4 corrupted to 0xDEAD → `err_cnt`=1, `first_err_idx`=4, `word_cnt`=6.
- `fifo_empty`=1 during the 2nd `memfifo_re` → `underflow`=1, no `fifo_re` that cycle. The session completes only after a 7th `memfifo_re` supplies the 6th read.
- `packet_no`=0 → `done` 2 cycles after `start`, `fifo_re` never asserted. A later `memfifo_re` sets `spurious`.
- `rst` asserted 1 cycle after a `fifo_re` mid-session → next cycle IDLE, all outputs 0, no compare of the in-flight word.
- `RD_LATENCY`=3, `memfifo_re` held high 4 cycles, `packet_no`=2 → 4 consecutive `fifo_re`, `done` at last `fifo_re`+5, `word_cnt`=4.

Source files
------------

// File: rtl/memfifo_rd_checker_pkg.sv
// Shared types and helpers for the memory FIFO read checker.
// Holds the FSM state encoding, the count width and the pattern expansion helper.
package memfifo_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CNT_W      = 17;
    localparam int MAX_DATA_W = 256;

    // Zero-extends the low `width` bits of the expected pattern to the full compare width.
    function automatic logic [MAX_DATA_W-1:0] expand_pattern(input logic [MAX_DATA_W-1:0] value,
                                                            input int width);
        logic [MAX_DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < width) r[i] = value[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/memfifo_rd_checker_if.sv
// Session control, read-request and FIFO read-port signals of the read checker.
interface memfifo_rd_checker_if #(parameter int DATA_WIDTH = 64);
    import memfifo_chk_pkg::*;

    // Handshake: memfifo_re is a one-cycle request per word; fifo_re is the same-cycle
    // grant (never asserted while fifo_empty); fifo_rdata is valid RD_LATENCY cycles after a grant.
    logic                  start;
    logic [15:0]           packet_no;
    logic                  memfifo_re;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_re;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      word_cnt;
    logic [15:0]           err_cnt;
    logic                  underflow;
    logic                  spurious;
    logic [CNT_W-1:0]      first_err_idx;

    modport master (
        output start, packet_no, memfifo_re, fifo_empty, fifo_rdata,
        input  fifo_re, busy, done, word_cnt, err_cnt, underflow, spurious, first_err_idx
    );

    modport slave (
        input  start, packet_no, memfifo_re, fifo_empty, fifo_rdata,
        output fifo_re, busy, done, word_cnt, err_cnt, underflow, spurious, first_err_idx
    );

endinterface

// File: rtl/memfifo_rd_checker_rd_valid_pipe.sv
// Delays the FIFO read grant by the FIFO read latency to mark when read data is valid.
module rd_valid_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_in,
    output logic vld_out,
    output logic pipe_empty
);

    logic [LATENCY-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= (sr << 1) | LATENCY'(vld_in);
    end

    assign vld_out    = sr[LATENCY-1];
    assign pipe_empty = ~|sr;

endmodule

// File: rtl/memfifo_rd_checker.sv
// Gates memfifo_re into FIFO reads and checks returned words against an incrementing pattern.
module memfifo_rd_checker
    import memfifo_chk_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    RD_LATENCY = 1,
    parameter int                    PKT_WORDS  = 2,
    parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    memfifo_rd_checker_if.slave  bus,
    output state_t               state_dbg
);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      target, issued, target_nxt;
    logic [DATA_WIDTH-1:0] expect_q;
    logic [CNT_W-1:0]      word_cnt, first_err_idx;
    logic [15:0]           err_cnt;
    logic                  underflow, spurious;
    logic                  fifo_re, vld_out, pipe_empty, mismatch, accept;

    assign target_nxt = CNT_W'(bus.packet_no) * CNT_W'(PKT_WORDS);
    assign accept     = (state == ST_IDLE) && bus.start;
    assign mismatch   = MAX_DATA_W'(bus.fifo_rdata) !=
                        expand_pattern(MAX_DATA_W'(expect_q), DATA_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // RUN leaves one cycle after the last grant, so DRAIN never sees a stale pipe_empty.
    always_comb begin
        state_nxt = state;
        fifo_re   = 1'b0;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = (target_nxt == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN: begin
                fifo_re = bus.memfifo_re & ~bus.fifo_empty & (issued < target);
                if (issued >= target) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (pipe_empty) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    rd_valid_pipe #(.LATENCY(RD_LATENCY)) u_vld_pipe (
        .clk        (clk),
        .rst        (rst),
        .vld_in     (fifo_re),
        .vld_out    (vld_out),
        .pipe_empty (pipe_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            target        <= '0;
            issued        <= '0;
            expect_q      <= SEED;
            word_cnt      <= '0;
            err_cnt       <= '0;
            underflow     <= 1'b0;
            spurious      <= 1'b0;
            first_err_idx <= '0;
        end else if (accept) begin
            target        <= target_nxt;
            issued        <= '0;
            expect_q      <= SEED;
            word_cnt      <= '0;
            err_cnt       <= '0;
            underflow     <= 1'b0;
            spurious      <= 1'b0;
            first_err_idx <= '0;
        end else begin
            if (fifo_re) issued <= issued + CNT_W'(1);
            if (state == ST_RUN && bus.memfifo_re && bus.fifo_empty) underflow <= 1'b1;
            if (state != ST_RUN && bus.memfifo_re) spurious <= 1'b1;
            if (vld_out) begin
                word_cnt <= word_cnt + CNT_W'(1);
                expect_q <= expect_q + DATA_WIDTH'(1);
                if (mismatch) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    if (err_cnt == 16'd0)    first_err_idx <= word_cnt;
                end
            end
        end
    end

    assign bus.fifo_re       = fifo_re;
    assign bus.busy          = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.done          = (state == ST_DONE);
    assign bus.word_cnt      = word_cnt;
    assign bus.err_cnt       = err_cnt;
    assign bus.underflow     = underflow;
    assign bus.spurious      = spurious;
    assign bus.first_err_idx = first_err_idx;
    assign state_dbg         = state;

endmodule

// File: tb/tb_memfifo_rd_checker.sv
// Directed bench for memfifo_rd_checker: FIFO models at latency 1 and 3, scoreboard on grants and done.
module tb_memfifo_rd_checker;
    import memfifo_chk_pkg::*;

    typedef struct {
        int          cyc;
        logic [16:0] word_cnt;
        logic [15:0] err_cnt;
        logic        underflow;
        logic        spurious;
        logic [16:0] first_err_idx;
    } done_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    memfifo_rd_checker_if #(.DATA_WIDTH(64)) a_if ();
    memfifo_rd_checker_if #(.DATA_WIDTH(64)) b_if ();
    state_t state_a, state_b;

    memfifo_rd_checker #(.DATA_WIDTH(64), .RD_LATENCY(1), .PKT_WORDS(2), .SEED(64'd0)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .state_dbg(state_a));
    memfifo_rd_checker #(.DATA_WIDTH(64), .RD_LATENCY(3), .PKT_WORDS(2), .SEED(64'd0)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .state_dbg(state_b));

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory FIFO models
    logic [63:0] mem_a[$];
    logic [63:0] mem_b[$];
    logic [63:0] rd_a;
    logic [63:0] rd_b[3];
    assign a_if.fifo_rdata = rd_a;
    assign b_if.fifo_rdata = rd_b[2];

    always @(posedge clk) begin
        logic [63:0] w;
        if (rst) rd_a <= '0;
        else if (a_if.fifo_re === 1'b1) begin
            w = (mem_a.size() > 0) ? mem_a.pop_front() : 64'd0;
            rd_a <= w;
        end
    end

    always @(posedge clk) begin
        logic [63:0] w;
        if (rst) begin
            rd_b[0] <= '0; rd_b[1] <= '0; rd_b[2] <= '0;
        end else begin
            w = 64'd0;
            if (b_if.fifo_re === 1'b1 && mem_b.size() > 0) w = mem_b.pop_front();
            rd_b[0] <= w;
            rd_b[1] <= rd_b[0];
            rd_b[2] <= rd_b[1];
        end
    end

    // Scoreboard
    logic [31:0] exp_re_a[$];
    logic [31:0] exp_re_b[$];
    done_rec_t   exp_done_a[$];
    done_rec_t   exp_done_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
    endtask

    task automatic check_done(input string tag, input done_rec_t e, input logic busy,
                              input logic [16:0] wc, input logic [15:0] ec, input logic uf,
                              input logic sp, input logic [16:0] fe);
        check({tag, "_done_cycle"}, cyc, e.cyc);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_word_cnt"}, wc, e.word_cnt);
        check({tag, "_err_cnt"}, ec, e.err_cnt);
        check({tag, "_underflow"}, uf, e.underflow);
        check({tag, "_spurious"}, sp, e.spurious);
        check({tag, "_first_err_idx"}, fe, e.first_err_idx);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.fifo_re === 1'b1) begin
                if (exp_re_a.size() == 0) unexpected("a_fifo_re");
                else check("a_fifo_re_cycle", cyc, exp_re_a.pop_front());
            end
            if (b_if.fifo_re === 1'b1) begin
                if (exp_re_b.size() == 0) unexpected("b_fifo_re");
                else check("b_fifo_re_cycle", cyc, exp_re_b.pop_front());
            end
            if (a_if.done === 1'b1) begin
                if (exp_done_a.size() == 0) unexpected("a_done");
                else check_done("a", exp_done_a.pop_front(), a_if.busy, a_if.word_cnt,
                                a_if.err_cnt, a_if.underflow, a_if.spurious, a_if.first_err_idx);
            end
            if (b_if.done === 1'b1) begin
                if (exp_done_b.size() == 0) unexpected("b_done");
                else check_done("b", exp_done_b.pop_front(), b_if.busy, b_if.word_cnt,
                                b_if.err_cnt, b_if.underflow, b_if.spurious, b_if.first_err_idx);
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [15:0] pk);
        a_if.start = 1'b1; a_if.packet_no = pk;
        tick(1);
        a_if.start = 1'b0;
    endtask

    task automatic re_a(input bit read_expected, input bit empty, output int at);
        a_if.memfifo_re = 1'b1; a_if.fifo_empty = empty;
        at = cyc;
        if (read_expected) exp_re_a.push_back(cyc);
        tick(1);
        a_if.memfifo_re = 1'b0; a_if.fifo_empty = 1'b0;
    endtask

    task automatic load_a(input logic [63:0] corrupt_idx, input logic [63:0] corrupt_val);
        mem_a.delete();
        for (int i = 0; i < 6; i++) mem_a.push_back(i == corrupt_idx ? corrupt_val : 64'(i));
    endtask

    task automatic push_done_a(input int c, input int wc, input int ec, input bit uf,
                               input bit sp, input int fe);
        done_rec_t r;
        r.cyc = c; r.word_cnt = 17'(wc); r.err_cnt = 16'(ec);
        r.underflow = uf; r.spurious = sp; r.first_err_idx = 17'(fe);
        exp_done_a.push_back(r);
    endtask

    task automatic check_idle(input string tag, input logic fr, input logic busy, input logic done,
                              input logic [16:0] wc, input logic [15:0] ec, input logic uf,
                              input logic sp, input logic [16:0] fe, input state_t st);
        check({tag, "_fifo_re"}, fr, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_word_cnt"}, wc, 17'd0);
        check({tag, "_err_cnt"}, ec, 16'd0);
        check({tag, "_underflow"}, uf, 1'b0);
        check({tag, "_spurious"}, sp, 1'b0);
        check({tag, "_first_err_idx"}, fe, 17'd0);
        check({tag, "_state"}, st, ST_IDLE);
    endtask

    initial begin
        int at;
        int s;
        a_if.start = 1'b0; a_if.packet_no = '0; a_if.memfifo_re = 1'b0; a_if.fifo_empty = 1'b0;
        b_if.start = 1'b0; b_if.packet_no = '0; b_if.memfifo_re = 1'b0; b_if.fifo_empty = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_idle("reset_a", a_if.fifo_re, a_if.busy, a_if.done, a_if.word_cnt, a_if.err_cnt,
                   a_if.underflow, a_if.spurious, a_if.first_err_idx, state_a);
        check_idle("reset_b", b_if.fifo_re, b_if.busy, b_if.done, b_if.word_cnt, b_if.err_cnt,
                   b_if.underflow, b_if.spurious, b_if.first_err_idx, state_b);

        // Clean session of 3 packets; a second start mid-run must be ignored
        load_a(64'hFF, 0);
        start_a(16'd3);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                a_if.start = 1'b1; a_if.packet_no = 16'd1;
                tick(1);
                a_if.start = 1'b0;
                tick(7);
            end else tick(8);
            re_a(1, 0, at);
        end
        push_done_a(at + 3, 6, 0, 0, 0, 0);
        tick(6);

        // Word 4 corrupted
        load_a(64'd4, 64'hDEAD);
        start_a(16'd3);
        for (int i = 0; i < 6; i++) begin
            tick(8);
            re_a(1, 0, at);
        end
        push_done_a(at + 3, 6, 1, 0, 0, 4);
        tick(6);

        // FIFO empty during the 2nd request
        load_a(64'hFF, 0);
        start_a(16'd3);
        for (int i = 0; i < 7; i++) begin
            tick(8);
            if (i == 1) re_a(0, 1, at);
            else        re_a(1, 0, at);
        end
        push_done_a(at + 3, 6, 0, 1, 0, 0);
        tick(6);

        // Zero-length session, then a request outside RUN
        s = cyc;
        start_a(16'd0);
        push_done_a(s + 2, 0, 0, 0, 0, 0);
        tick(4);
        re_a(0, 0, at);
        check("zero_len_spurious", a_if.spurious, 1'b1);
        check("zero_len_underflow", a_if.underflow, 1'b0);
        tick(2);

        // Reset one cycle after a grant discards the in-flight word
        load_a(64'hFF, 0);
        start_a(16'd3);
        tick(8);
        re_a(1, 0, at);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_idle("mid_rst_a", a_if.fifo_re, a_if.busy, a_if.done, a_if.word_cnt, a_if.err_cnt,
                   a_if.underflow, a_if.spurious, a_if.first_err_idx, state_a);
        tick(5);
        check("mid_rst_word_cnt_later", a_if.word_cnt, 17'd0);

        // Latency 3, back-to-back requests for 2 packets
        mem_b.delete();
        for (int i = 0; i < 4; i++) mem_b.push_back(64'(i));
        b_if.start = 1'b1; b_if.packet_no = 16'd2;
        tick(1);
        b_if.start = 1'b0;
        b_if.memfifo_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_re_b.push_back(cyc);
            at = cyc;
            tick(1);
        end
        b_if.memfifo_re = 1'b0;
        begin
            done_rec_t r;
            r.cyc = at + 5; r.word_cnt = 17'd4; r.err_cnt = 16'd0;
            r.underflow = 1'b0; r.spurious = 1'b0; r.first_err_idx = 17'd0;
            exp_done_b.push_back(r);
        end
        tick(10);

        check("a_re_left", exp_re_a.size(), 0);
        check("b_re_left", exp_re_b.size(), 0);
        check("a_done_left", exp_done_a.size(), 0);
        check("b_done_left", exp_done_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
